// File: rtl/ct_mmu_pkg.sv
// Shared MMU constants: invalidate command codes, sequencer states, page-size one-hots.
// Pure definitions; no logic, no latency.
package ct_mmu_pkg;

    localparam int IDX_WIDTH_D  = 9;
    localparam int VPN_WIDTH_D  = 27;
    localparam int TAG_WIDTH_D  = 48;
    localparam int DATA_WIDTH_D = 42;
    localparam int BANK_NUM_D   = 4;

    localparam logic [1:0] INV_TYPE_ALL  = 2'b00;
    localparam logic [1:0] INV_TYPE_VA   = 2'b01;
    localparam logic [1:0] INV_TYPE_IDX  = 2'b10;

    localparam logic [2:0] PGS_4K = 3'b001;
    localparam logic [2:0] PGS_2M = 3'b010;
    localparam logic [2:0] PGS_1G = 3'b100;

    localparam logic [1:0] PSTEP_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_CMPLT = 2'b10
    } seq_state_e;

    typedef enum logic [1:0] {
        CMD_ALL = 2'b00,
        CMD_VA  = 2'b01,
        CMD_IDX = 2'b10
    } inv_cmd_e;

    // The reserved type code 11 folds into the full walk.
    function automatic inv_cmd_e decode_inv_type(input logic [1:0] t);
        case (t)
            INV_TYPE_VA:  return CMD_VA;
            INV_TYPE_IDX: return CMD_IDX;
            default:      return CMD_ALL;
        endcase
    endfunction

    function automatic logic [2:0] pgs_of_step(input logic [1:0] s);
        case (s)
            2'd0:    return PGS_4K;
            2'd1:    return PGS_2M;
            default: return PGS_1G;
        endcase
    endfunction

endpackage

// File: rtl/ct_mmu_tlbinv_seq_if.sv
// CP0 command side and tlboper arbiter side of the TLB-invalidate sequencer.
// master = sequencer, slave = CP0/arbiter counterpart.
interface ct_mmu_tlbinv_seq_if
    import ct_mmu_pkg::*;
#(
    parameter int IDX_WIDTH  = IDX_WIDTH_D,
    parameter int VPN_WIDTH  = VPN_WIDTH_D,
    parameter int TAG_WIDTH  = TAG_WIDTH_D,
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int BANK_NUM   = BANK_NUM_D
);
    logic                  cp0_inv_req;
    logic [1:0]            cp0_inv_type;
    logic [VPN_WIDTH-1:0]  cp0_inv_vpn;
    logic [IDX_WIDTH-1:0]  cp0_inv_idx;
    logic [BANK_NUM-1:0]   cp0_inv_bank;
    logic                  arb_seq_grant;

    logic                  seq_cp0_ack;
    logic                  seq_arb_req;
    logic [IDX_WIDTH-1:0]  seq_arb_idx;
    logic                  seq_arb_idx_not_va;
    logic [BANK_NUM-1:0]   seq_arb_bank_sel;
    logic [VPN_WIDTH-1:0]  seq_arb_vpn;
    logic                  seq_arb_cmp_va;
    logic                  seq_arb_write;
    logic                  seq_arb_fifo_write;
    logic [3:0]            seq_arb_fifo_din;
    logic [TAG_WIDTH-1:0]  seq_arb_tag_din;
    logic [DATA_WIDTH-1:0] seq_arb_data_din;
    logic [2:0]            seq_xx_pgs;
    logic                  seq_xx_pgs_en;
    logic                  seq_xx_cmplt;
    logic                  seq_busy;

    modport master (
        input  cp0_inv_req, cp0_inv_type, cp0_inv_vpn, cp0_inv_idx, cp0_inv_bank,
               arb_seq_grant,
        output seq_cp0_ack, seq_arb_req, seq_arb_idx, seq_arb_idx_not_va,
               seq_arb_bank_sel, seq_arb_vpn, seq_arb_cmp_va, seq_arb_write,
               seq_arb_fifo_write, seq_arb_fifo_din, seq_arb_tag_din,
               seq_arb_data_din, seq_xx_pgs, seq_xx_pgs_en, seq_xx_cmplt, seq_busy
    );

    modport slave (
        output cp0_inv_req, cp0_inv_type, cp0_inv_vpn, cp0_inv_idx, cp0_inv_bank,
               arb_seq_grant,
        input  seq_cp0_ack, seq_arb_req, seq_arb_idx, seq_arb_idx_not_va,
               seq_arb_bank_sel, seq_arb_vpn, seq_arb_cmp_va, seq_arb_write,
               seq_arb_fifo_write, seq_arb_fifo_din, seq_arb_tag_din,
               seq_arb_data_din, seq_xx_pgs, seq_xx_pgs_en, seq_xx_cmplt, seq_busy
    );

endinterface

// File: rtl/ct_mmu_tlbinv_cnt.sv
// Index walk counter and page-size step with last-access detect for the invalidate sequencer.
// Advances one step per granted access; holds while not advanced.
module ct_mmu_tlbinv_cnt
    import ct_mmu_pkg::*;
#(
    parameter int IDX_WIDTH = IDX_WIDTH_D
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 clr_i,
    input  logic                 adv_i,
    input  inv_cmd_e             cmd_i,
    output logic [IDX_WIDTH-1:0] cnt_o,
    output logic [1:0]           pstep_o,
    output logic                 last_o
);
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           pstep_q, pstep_d;

    always_comb begin
        last_o = 1'b1;
        case (cmd_i)
            CMD_ALL: last_o = &cnt_q;
            CMD_VA:  last_o = (pstep_q == PSTEP_LAST);
            default: last_o = 1'b1;
        endcase
    end

    // The index wraps naturally to 0 on the final grant of a full walk.
    always_comb begin
        cnt_d   = cnt_q;
        pstep_d = pstep_q;
        if (clr_i) begin
            cnt_d   = '0;
            pstep_d = '0;
        end else if (adv_i) begin
            if (cmd_i == CMD_ALL) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cmd_i == CMD_VA) begin
                pstep_d = last_o ? 2'd0 : pstep_q + 2'd1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            cnt_q   <= '0;
            pstep_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pstep_q <= pstep_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign pstep_o = pstep_q;

endmodule

// File: rtl/ct_mmu_tlbinv_seq.sv
// Turns one CP0 TLB-invalidate command into a series of jTLB write accesses on the tlboper port.
// First access one cycle after ack; each access is held until granted, then a one-cycle cmplt.
module ct_mmu_tlbinv_seq
    import ct_mmu_pkg::*;
#(
    parameter int IDX_WIDTH  = IDX_WIDTH_D,
    parameter int VPN_WIDTH  = VPN_WIDTH_D,
    parameter int TAG_WIDTH  = TAG_WIDTH_D,
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int BANK_NUM   = BANK_NUM_D
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    ct_mmu_tlbinv_seq_if.master  bus
);
    seq_state_e           state_q, state_d;
    inv_cmd_e             cmd_q;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [BANK_NUM-1:0]  bank_q;

    logic [IDX_WIDTH-1:0] cnt;
    logic [1:0]           pstep;
    logic                 last;
    logic                 accept;
    logic                 take;

    assign accept = (state_q == ST_IDLE) && bus.cp0_inv_req && !cpurst;
    assign take   = (state_q == ST_ISSUE) && bus.arb_seq_grant;

    ct_mmu_tlbinv_cnt #(.IDX_WIDTH(IDX_WIDTH)) u_cnt (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .clr_i          (accept),
        .adv_i          (take),
        .cmd_i          (cmd_q),
        .cnt_o          (cnt),
        .pstep_o        (pstep),
        .last_o         (last)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_ALL;
            vpn_q   <= '0;
            idx_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q  <= decode_inv_type(bus.cp0_inv_type);
                vpn_q  <= bus.cp0_inv_vpn;
                idx_q  <= bus.cp0_inv_idx;
                bank_q <= bus.cp0_inv_bank;
            end
        end
    end

    // Outputs are forced low during reset so an aborted command never leaks a request.
    always_comb begin
        state_d                = state_q;
        bus.seq_cp0_ack        = 1'b0;
        bus.seq_arb_req        = 1'b0;
        bus.seq_arb_idx        = '0;
        bus.seq_arb_idx_not_va = 1'b0;
        bus.seq_arb_bank_sel   = '0;
        bus.seq_arb_vpn        = '0;
        bus.seq_arb_cmp_va     = 1'b0;
        bus.seq_arb_write      = 1'b0;
        bus.seq_arb_fifo_write = 1'b0;
        bus.seq_arb_fifo_din   = '0;
        bus.seq_arb_tag_din    = '0;
        bus.seq_arb_data_din   = '0;
        bus.seq_xx_pgs         = '0;
        bus.seq_xx_pgs_en      = 1'b0;
        bus.seq_xx_cmplt       = 1'b0;
        bus.seq_busy           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bus.seq_cp0_ack = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.seq_busy         = !cpurst;
                bus.seq_arb_req      = !cpurst;
                bus.seq_arb_write    = !cpurst;
                bus.seq_arb_bank_sel = cpurst ? '0 : '1;
                if (!cpurst) begin
                    case (cmd_q)
                        CMD_VA: begin
                            bus.seq_arb_vpn    = vpn_q;
                            bus.seq_arb_cmp_va = 1'b1;
                            bus.seq_xx_pgs_en  = 1'b1;
                            bus.seq_xx_pgs     = pgs_of_step(pstep);
                        end
                        CMD_IDX: begin
                            bus.seq_arb_idx        = idx_q;
                            bus.seq_arb_idx_not_va = 1'b1;
                            bus.seq_arb_bank_sel   = bank_q;
                        end
                        default: begin
                            bus.seq_arb_idx        = cnt;
                            bus.seq_arb_idx_not_va = 1'b1;
                            bus.seq_arb_fifo_write = 1'b1;
                        end
                    endcase
                end
                if (take && last) begin
                    state_d = ST_CMPLT;
                end
            end
            ST_CMPLT: begin
                bus.seq_busy     = !cpurst;
                bus.seq_xx_cmplt = !cpurst;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ct_mmu_tlbinv_seq.sv
module tb_ct_mmu_tlbinv_seq;
    import ct_mmu_pkg::*;

    localparam int BW = 160;

    typedef struct packed {
        logic [8:0]  idx;
        logic        inv;
        logic [3:0]  bank;
        logic [26:0] vpn;
        logic        cmp;
        logic        wr;
        logic        fwr;
        logic [2:0]  pgs;
        logic        pgs_en;
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ct_mmu_tlbinv_seq_if bus ();

    ct_mmu_tlbinv_seq dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus.master)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    acc_t expq[$];
    acc_t zero_acc = '0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] observed();
        return BW'({bus.seq_cp0_ack, bus.seq_xx_cmplt, bus.seq_busy, bus.seq_arb_req,
                    bus.seq_arb_idx, bus.seq_arb_idx_not_va, bus.seq_arb_bank_sel,
                    bus.seq_arb_vpn, bus.seq_arb_cmp_va, bus.seq_arb_write,
                    bus.seq_arb_fifo_write, bus.seq_xx_pgs, bus.seq_xx_pgs_en,
                    bus.seq_arb_fifo_din, bus.seq_arb_tag_din, bus.seq_arb_data_din});
    endfunction

    function automatic logic [BW-1:0] expected(input acc_t a, input logic ack,
                                               input logic cmplt, input logic busy,
                                               input logic req);
        return BW'({ack, cmplt, busy, req, a, 4'b0, 48'b0, 42'b0});
    endfunction

    // Reference: the ordered list of accesses a command must produce.
    task automatic build(input logic [1:0] typ, input logic [26:0] vpn,
                         input logic [8:0] idx, input logic [3:0] bank);
        acc_t a;
        expq.delete();
        if (typ == 2'b01) begin
            for (int s = 0; s < 3; s++) begin
                a = '0; a.vpn = vpn; a.cmp = 1'b1; a.wr = 1'b1; a.bank = 4'hf;
                a.pgs = 3'(1 << s); a.pgs_en = 1'b1;
                expq.push_back(a);
            end
        end else if (typ == 2'b10) begin
            a = '0; a.idx = idx; a.inv = 1'b1; a.bank = bank; a.wr = 1'b1;
            expq.push_back(a);
        end else begin
            for (int i = 0; i < 512; i++) begin
                a = '0; a.idx = 9'(i); a.inv = 1'b1; a.bank = 4'hf; a.wr = 1'b1; a.fwr = 1'b1;
                expq.push_back(a);
            end
        end
    endtask

    // gmode: 0 grant always, 1 random grant, 2 grant low for 'stall' cycles then high.
    task automatic run_cmd(input logic [1:0] typ, input logic [26:0] vpn, input logic [8:0] idx,
                           input logic [3:0] bank, input int gmode, input int stall,
                           input bit hold, input int abort_at);
        int cyc;
        int ngr;
        build(typ, vpn, idx, bank);
        @(negedge clk);
        bus.cp0_inv_req  = 1'b1;
        bus.cp0_inv_type = typ;
        bus.cp0_inv_vpn  = vpn;
        bus.cp0_inv_idx  = idx;
        bus.cp0_inv_bank = bank;
        bus.arb_seq_grant = 1'b0;
        #1 chk("accept", observed(), expected(zero_acc, 1, 0, 0, 0));
        cyc = 0;
        ngr = 0;
        while (expq.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            if (!hold) bus.cp0_inv_req = 1'b0;
            case (gmode)
                0:       bus.arb_seq_grant = 1'b1;
                1:       bus.arb_seq_grant = 1'($urandom_range(0, 1));
                default: bus.arb_seq_grant = (cyc >= stall);
            endcase
            if (abort_at >= 0 && ngr == abort_at) begin
                rst = 1'b1;
                bus.arb_seq_grant = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1 chk("abort_idle", observed(), expected(zero_acc, 0, 0, 0, 0));
                @(negedge clk);
                #1 chk("abort_nocmplt", observed(), expected(zero_acc, 0, 0, 0, 0));
                expq.delete();
                return;
            end
            #1 chk("issue", observed(), expected(expq[0], 0, 0, 1, 1));
            if (bus.arb_seq_grant) begin
                void'(expq.pop_front());
                ngr++;
            end
            cyc++;
        end
        if (expq.size() > 0) chk("timeout", BW'(expq.size()), BW'(0));
        @(negedge clk);
        bus.arb_seq_grant = 1'($urandom_range(0, 1));
        #1 chk("cmplt", observed(), expected(zero_acc, 0, 1, 1, 0));
        @(negedge clk);
        bus.arb_seq_grant = 1'b0;
        if (hold) begin
            #1 chk("reack", observed(), expected(zero_acc, 1, 0, 0, 0));
        end else begin
            #1 chk("idle", observed(), expected(zero_acc, 0, 0, 0, 0));
        end
        bus.cp0_inv_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cp0_inv_req   = 1'b0;
        bus.cp0_inv_type  = 2'b00;
        bus.cp0_inv_vpn   = '0;
        bus.cp0_inv_idx   = '0;
        bus.cp0_inv_bank  = '0;
        bus.arb_seq_grant = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("reset", observed(), expected(zero_acc, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset", observed(), expected(zero_acc, 0, 0, 0, 0));

        run_cmd(2'b00, 27'h0, 9'h0, 4'h0, 0, 0, 1'b0, -1);
        run_cmd(2'b01, 27'h1234567, 9'h0, 4'h0, 0, 0, 1'b0, -1);
        run_cmd(2'b10, 27'h0, 9'h1A5, 4'b0100, 2, 5, 1'b0, -1);
        run_cmd(2'b00, 27'h0, 9'h0, 4'h0, 1, 0, 1'b0, -1);
        run_cmd(2'b00, 27'h0, 9'h0, 4'h0, 0, 0, 1'b0, 200);
        run_cmd(2'b10, 27'h0, 9'h03C, 4'b1001, 0, 0, 1'b0, -1);
        run_cmd(2'b11, 27'h0, 9'h0, 4'h0, 0, 0, 1'b1, -1);

        @(negedge clk);
        rst = 1'b1;
        bus.cp0_inv_req = 1'b1;
        #1 chk("rst_req_noack", observed(), expected(zero_acc, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        bus.cp0_inv_req = 1'b0;
        #1 chk("rst_req_idle", observed(), expected(zero_acc, 0, 0, 0, 0));

        for (int k = 0; k < 6; k++) begin
            run_cmd(2'($urandom_range(0, 3)), 27'($urandom), 9'($urandom), 4'($urandom),
                    1, 0, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ct_mmu_tlbinv_seq.md
# ct_mmu_tlbinv_seq

Sequencer that turns one CP0 TLB-invalidate command into the series of jTLB write accesses needed to carry it out. It drives the tlboper request port of the MMU arbiter and holds each access until the arbiter grants it. It signals completion so the arbiter can release its tlboper stall. Three commands are supported: invalidate all entries (a walk over every index), invalidate by VA (one compare-and-clear per page size), and invalidate a single index.

## Interface
Parameters:
- IDX_WIDTH, 9, jTLB index width (512 sets)
- VPN_WIDTH, 27, VPN width
- TAG_WIDTH, 48, jTLB tag width
- DATA_WIDTH, 42, jTLB data width
- BANK_NUM, 4, number of jTLB ways

Ports:
- forever_cpuclk  in  1  clock; the only clock
- cpurst  in  1  reset, synchronous, active-high
- cp0_inv_req  in  1  command request; held until `seq_cp0_ack`
- cp0_inv_type  in  2  command type: 00 ALL, 01 VA, 10 IDX, 11 treated as ALL
- cp0_inv_vpn  in  VPN_WIDTH  VPN for the VA command
- cp0_inv_idx  in  IDX_WIDTH  index for the IDX command
- cp0_inv_bank  in  BANK_NUM  way mask for the IDX command
- arb_seq_grant  in  1  arbiter grant for the tlboper port
- seq_cp0_ack  out  1  one-cycle pulse when a command is accepted
- seq_arb_req  out  1  access request (tlboper_arb_req)
- seq_arb_idx  out  IDX_WIDTH  access index
- seq_arb_idx_not_va  out  1  use `seq_arb_idx` instead of the VA-derived index
- seq_arb_bank_sel  out  BANK_NUM  way select
- seq_arb_vpn  out  VPN_WIDTH  compare VPN
- seq_arb_cmp_va  out  1  compare-with-VA access
- seq_arb_write  out  1  tag write
- seq_arb_fifo_write  out  1  replacement-FIFO write
- seq_arb_fifo_din  out  4  FIFO data; always 0
- seq_arb_tag_din  out  TAG_WIDTH  tag data; always 0 (valid bit cleared)
- seq_arb_data_din  out  DATA_WIDTH  data; always 0
- seq_xx_pgs  out  3  one-hot page size {1g,2m,4k} for the index select
- seq_xx_pgs_en  out  1  page-size override enable
- seq_xx_cmplt  out  1  one-cycle completion pulse (tlboper_xx_cmplt)
- seq_busy  out  1  command in progress

## Operation
States: IDLE, ISSUE, CMPLT.
- IDLE:
  - `cp0_inv_req` = 1 → `seq_cp0_ack` = 1 in the same cycle.
  - Latch type, vpn, idx and bank.
  - Clear the index counter `cnt` (9 bit) and the page-size step `pstep` (2 bit).
  - Next state ISSUE.
- ISSUE:
  - `seq_arb_req` = 1 throughout.
  - All access fields are stable while `arb_seq_grant` = 0.
  - On a grant cycle, the access is taken in that cycle and the sequencer advances.
- ALL command:
  - idx = `cnt`, idx_not_va = 1, bank_sel = 1111, write = 1, fifo_write = 1, cmp_va = 0, pgs_en = 0.
  - On grant, `cnt` += 1.
  - The grant with `cnt` = 511 is the last access; `cnt` wraps to 0 and the state goes to CMPLT.
- VA command:
  - vpn = latched vpn, cmp_va = 1, write = 1, fifo_write = 0, bank_sel = 1111, idx_not_va = 0, pgs_en = 1.
  - pgs follows `pstep`: 0 → 001 (4k), 1 → 010 (2m), 2 → 100 (1g).
  - Grant at `pstep` = 2 → CMPLT.
  - The jTLB clears only ways whose tag matches.
- IDX command:
  - idx = latched idx, idx_not_va = 1, bank_sel = latched bank, write = 1, fifo_write = 0, cmp_va = 0, pgs_en = 0.
  - One grant → CMPLT.
- CMPLT:
  - `seq_xx_cmplt` = 1 for one cycle, then IDLE.
  - `cp0_inv_req` is ignored in CMPLT; a new command is accepted in IDLE at the earliest one cycle after the completion pulse.
- When `seq_arb_req` = 0, all other seq_arb_* and seq_xx_* outputs are 0.
- `seq_busy` = 1 in ISSUE and CMPLT.

## Timing
- Reset: state IDLE, `cnt` = 0, `pstep` = 0, all outputs 0. Reset mid-command aborts it with no completion pulse.
- Accept at cycle T. `seq_arb_req` rises at T+1.
- With continuous grant:
  - ALL grants at T+1..T+512, `seq_xx_cmplt` at T+513.
  - VA grants at T+1..T+3, cmplt at T+4.
  - IDX grant at T+1, cmplt at T+2.
- Grant stalls (PTW priority, `jtlb_arb_sel_4k` low) only delay the sequence; no access is skipped or repeated.
- `arb_seq_grant` is ignored outside ISSUE.
- Simultaneous `cp0_inv_req` and reset: reset wins, no ack.

## Structure
- Shared package `ct_mmu_pkg`:
  - constants for `cp0_inv_type` codes;
  - state encoding (IDLE 2'b00, ISSUE 2'b01, CMPLT 2'b10);
  - one-hot PGS constants;
  - IDX_WIDTH, TAG_WIDTH and DATA_WIDTH defaults.
- One natural sub-module, `ct_mmu_tlbinv_cnt`: the index and page-step counter with last-access detect.
- The FSM and output muxing stay in the top module.

## Test plan
- ALL command with grant held at 1: 512 accesses with idx 0..511, bank 1111, write and fifo_write both 1; cmplt 513 cycles after ack; `cnt` back to 0.
- VA command, vpn 0x1234567, grant held at 1: 3 accesses with pgs 001, 010, 100; cmp_va = 1; vpn constant; cmplt at T+4.
- IDX command, idx 0x1A5, bank 0100: grant held at 0 for 5 cycles, then 1. All fields stable during the stall; a single access; cmplt the following cycle.
- ALL command with grant toggled pseudo-randomly: every index 0..511 is granted exactly once and in order.
- Reset asserted in ISSUE at `cnt` = 200: next cycle IDLE with all outputs 0 and no cmplt; a new IDX command afterwards completes normally.
- Type 11: behaves exactly as ALL. `cp0_inv_req` held high through CMPLT: no second ack until the IDLE cycle after the cmplt pulse.
